motor_pwm_driver: RTL
=====================

Name: motor_pwm_driver

Overview:
- Motor-side receiver of the operator-panel command pair: `motor_running` (run level) and `motor_pwm` (speed-increase request).
- Turns the commands into a glitch-free fixed-period PWM waveform for the motor power stage.
- Ramps duty softly toward a target and steps the target up on each increase request.
- Sits between the operator-panel FSM and the power-stage gate driver.

Parameters:
- PERIOD, 250: PWM period in clk cycles. Legal range 2..255.
- DUTY_INIT, 50: target duty (high cycles per period) loaded on each start. Must be ≤ PERIOD.
- DUTY_STEP, 25: target increment per increase request.
- RAMP_DIV, 16: clk cycles per ±1 duty step while ramping. Must be ≥ 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-low.
- motor_running, input, 1: run command level; asynchronous to clk.
- motor_pwm, input, 1: increase request; a rising edge means one step; asynchronous to clk.
- pwm_out, output, 1: PWM drive to the power stage; registered.
- duty_level, output, 8: current ramped duty value.
- target_level, output, 8: current duty target.
- at_target, output, 1: high when in RUN with duty_level == target_level.
- stopping, output, 1: high in RAMP_DOWN.

Behaviour:
- Decided: one clock `clk`. Reset `rst` is asynchronous and active-low.
- Reset values:
  - pwm_out=0, duty_level=0, target_level=0, at_target=0, stopping=0.
  - State=IDLE, PWM counter=0, synchroniser flops=0.
- Input conditioning:
  - Both inputs pass through 2-flop synchronisers.
  - Increase edge = sync2 & ~sync3, a one-cycle pulse.
  - Input-to-internal latency is 3 clk.
- PWM counter:
  - Free-running 0..PERIOD-1, wraps to 0.
  - Shadow duty register loads duty_level only when counter == PERIOD-1.
  - pwm_out registered as (counter < shadow).
  - A duty change never alters the period in progress.
  - shadow=0 gives constant low; shadow=PERIOD gives constant high.
- FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN.
  - IDLE: duty_level=0. Synchronised run=1 → target_level=DUTY_INIT, go to RAMP_UP. Increase edges are ignored.
  - RAMP_UP: ramp-tick counter counts 0..RAMP_DIV-1. On the tick, duty_level+1. When duty_level == target_level → RUN. If target_level == duty_level on entry, go to RUN next cycle.
  - RUN: at_target=1. Increase edge → target_level = min(target_level+DUTY_STEP, PERIOD), computed 9-bit then saturated. If the target changed, go to RAMP_UP. If already at PERIOD, no change and stay in RUN.
  - RAMP_DOWN: stopping=1. duty_level-1 per tick. At duty_level==0 → IDLE and target_level=0.
- Run deassertion:
  - Synchronised run=0 in RAMP_UP or RUN → RAMP_DOWN.
  - Takes priority over a same-cycle increase edge.
  - The ramp-tick counter clears on every state change.
- Run reasserted during RAMP_DOWN → RAMP_UP from the current duty_level, target_level=DUTY_INIT.
  - If duty_level > DUTY_INIT, the FSM ramps down toward the target instead of up, then enters RUN at equality.
  - In that case RAMP_UP must step in the direction of the target.
- Increase edge during RAMP_UP: the target updates with the same saturation rule and the ramp continues.
- Reset asserted mid-operation: all state clears immediately. pwm_out drops the same instant (asynchronous).

Optional Feature:
- Macro: MOTOR_PWM_SOFTSTOP_EN.
- Defined: behaviour as above; stopping ramps down.
- Undefined:
  - RAMP_DOWN state is not built and stopping is tied 0.
  - Run deassertion forces duty_level=0 and target_level=0, and the state goes to IDLE next clk.
  - pwm_out still falls only at the next period boundary via the shadow register, unless reset is asserted.

Decomposition:
- Shared package motor_pkg holds:
  - state encoding constants for the 4 FSM states;
  - duty width constant (8);
  - default PERIOD/DUTY_INIT/DUTY_STEP values used by both the panel FSM and this block.
- One sub-module: pwm_gen, containing the period counter, shadow register and comparator. Inputs clk, rst, duty; output pwm_out.
- The FSM, ramp logic and synchronisers stay in the top module.

Test Plan:
- Bench parameters PERIOD=250, DUTY_INIT=50, DUTY_STEP=25, RAMP_DIV=4.
- Start: rst released, motor_running=1 → target_level=50 after 3 clk; duty_level reaches 50 after 200 further clk; at_target=1; pwm_out high 50 of every 250 clk in the next full period.
- Increase with saturation: in RUN at 50, apply 9 motor_pwm pulses spaced 1200 clk → target steps 75,100,…,250, then stays at 250; final pwm_out is constant high.
- Glitch-free update: raise the target mid-period (counter=100) → the current period keeps the old high count; the new duty appears only from the next counter wrap.
- Soft stop (macro defined): drop motor_running at duty 100 → stopping=1; duty_level reaches 0 after 400 clk; state IDLE; pwm_out constant low.
- Restart during stop: reassert run at duty 80 during RAMP_DOWN → the ramp moves toward 50; at_target=1 at 50; a simultaneous increase edge with run=0 is ignored.
- Hard stop (macro undefined) and reset: drop run at duty 100 → duty_level=0 next clk, pwm_out low by the next period boundary. Asserting rst mid-period drops pwm_out immediately and all outputs read 0.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared constants for the operator-panel / motor-driver command pair.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state encodings, duty width, default PWM settings, and the
// saturating target-step helper used wherever the duty target is raised.
package motor_pkg;

  localparam int DUTY_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  localparam int PERIOD_DEF    = 250;
  localparam int DUTY_INIT_DEF = 50;
  localparam int DUTY_STEP_DEF = 25;
  localparam int RAMP_DIV_DEF  = 16;

  // Raise a duty target by one step, computed one bit wider so the sum
  // cannot wrap, then clamp to the PWM period (constant-high duty).
  function automatic logic [DUTY_W-1:0] step_target(
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W:0]   step,
    input logic [DUTY_W:0]   limit
  );
    logic [DUTY_W:0] sum;
    sum = {1'b0, tgt} + step;
    if (sum > limit) begin
      sum = limit;
    end
    return sum[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/motor_pwm_driver_pwm_gen.sv
// Fixed-period PWM generator with a period-boundary shadow duty register.
// Latency: duty sampled at counter==PERIOD-1, visible on pwm_out from the next period.
// Backpressure: none; free-running, duty may change at any time without glitching.
// Ports: clk, rst (async active-low), duty [DUTY_W-1:0] in, pwm_out (registered) out.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic              pwm_q, pwm_d;
  logic              wrap;

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + DUTY_W'(1);
    // Duty is only captured at the wrap, so a period in progress always
    // completes with the high count it started with.
    shadow_d = wrap ? duty : shadow_q;
    // shadow==0 never satisfies the compare (always low); shadow==PERIOD
    // always does (always high).
    pwm_d    = (cnt_q < shadow_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor-side PWM driver: synchronises run/increase commands, ramps duty toward a target.
// Latency: 3 clk from input pin to FSM action; duty reaches pwm_out at the next period wrap.
// Backpressure: none; increase edges arriving while idle or stopping are dropped.
// Ports: clk, rst (async active-low), motor_running, motor_pwm (async level inputs);
//        pwm_out, duty_level[7:0], target_level[7:0], at_target, stopping outputs.
// Build option: define MOTOR_PWM_SOFTSTOP_EN to ramp duty down on stop; otherwise a
//        stop clears duty immediately and stopping is tied low.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF,
  parameter int DUTY_STEP = DUTY_STEP_DEF,
  parameter int RAMP_DIV  = RAMP_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              motor_running,
  input  logic              motor_pwm,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_level,
  output logic [DUTY_W-1:0] target_level,
  output logic              at_target,
  output logic              stopping
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] INIT_V    = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W:0]   STEP_V    = (DUTY_W + 1)'(DUTY_STEP);
  localparam logic [DUTY_W:0]   LIMIT_V   = (DUTY_W + 1)'(PERIOD);

  // Input synchronisers; the third increase flop only exists to detect edges.
  logic run_s1_q, run_s2_q;
  logic inc_s1_q, inc_s2_q, inc_s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      inc_s1_q <= 1'b0;
      inc_s2_q <= 1'b0;
      inc_s3_q <= 1'b0;
    end else begin
      run_s1_q <= motor_running;
      run_s2_q <= run_s1_q;
      inc_s1_q <= motor_pwm;
      inc_s2_q <= inc_s1_q;
      inc_s3_q <= inc_s2_q;
    end
  end

  logic [1:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  tick_q, tick_d;

  logic              run_s;
  logic              inc_edge;
  logic              tick;
  logic              ramping;
  logic              stop_req;
  logic [DUTY_W-1:0] bumped;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;

    run_s    = run_s2_q;
    inc_edge = inc_s2_q & ~inc_s3_q;
    tick     = (tick_q == TICK_LAST);
    ramping  = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    bumped   = step_target(target_q, STEP_V, LIMIT_V);
    // Dropping run beats any increase edge seen in the same cycle.
    stop_req = !run_s && ((state_q == ST_RAMP_UP) || (state_q == ST_RUN));

    case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        if (run_s) begin
          target_d = INIT_V;
          state_d  = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (inc_edge) begin
          target_d = bumped;
        end
        // RAMP_UP steps toward the target in either direction: after a
        // restart from a soft stop the duty may sit above DUTY_INIT.
        if (duty_q == target_d) begin
          state_d = ST_RUN;
        end else if (tick) begin
          duty_d = (duty_q < target_d) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
        end
      end
      ST_RUN: begin
        // A saturated target does not change, so no ramp is started.
        if (inc_edge && (bumped != target_q)) begin
          target_d = bumped;
          state_d  = ST_RAMP_UP;
        end
      end
`ifdef MOTOR_PWM_SOFTSTOP_EN
      ST_RAMP_DOWN: begin
        if (run_s) begin
          target_d = INIT_V;
          state_d  = ST_RAMP_UP;
        end else if (duty_q == '0) begin
          target_d = '0;
          state_d  = ST_IDLE;
        end else if (tick) begin
          duty_d = duty_q - DUTY_W'(1);
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        duty_d   = '0;
        target_d = '0;
      end
    endcase

    if (stop_req) begin
`ifdef MOTOR_PWM_SOFTSTOP_EN
      duty_d   = duty_q;
      target_d = target_q;
      state_d  = ST_RAMP_DOWN;
`else
      // Hard stop: duty is cleared now, but pwm_out still finishes the
      // current period because pwm_gen only samples duty at its wrap.
      duty_d   = '0;
      target_d = '0;
      state_d  = ST_IDLE;
`endif
    end

    // Ramp timing restarts from zero on every state change.
    if ((state_d != state_q) || tick || !ramping) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      tick_q   <= tick_d;
    end
  end

  pwm_gen #(
    .PERIOD (PERIOD)
  ) u_pwm_gen (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign duty_level   = duty_q;
  assign target_level = target_q;
  assign at_target    = (state_q == ST_RUN) && (duty_q == target_q);
`ifdef MOTOR_PWM_SOFTSTOP_EN
  assign stopping     = (state_q == ST_RAMP_DOWN);
`else
  assign stopping     = 1'b0;
`endif

endmodule
